// File: rtl/q_mult.sv
// Sequential signed multiplier: radix-2 shift-add over operand magnitudes with a final sign fix.
// Fixed latency of N+1 clocks from acceptance to product_dout_vld, independent of operand values.
module q_mult #(
    parameter int N = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          input_vld,
    input  logic [N-1:0]  multiplicand_din,
    input  logic [N-1:0]  multiplier_din,
    output logic [31:0]   product_dout,
    output logic          product_dout_vld,
    output logic          product_end
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [2*N-1:0]   r_acc;
    logic [2*N-1:0]   r_mcand;
    logic [N-1:0]     r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_sign;

    logic [N-1:0]     w_mcand_mag;
    logic [N-1:0]     w_mplier_mag;
    logic [31:0]      w_acc_ext;
    logic [31:0]      w_product;

    // Magnitude of -2^(N-1) wraps to 2^(N-1), which is exact as an N-bit unsigned value.
    assign w_mcand_mag  = multiplicand_din[N-1] ? -multiplicand_din : multiplicand_din;
    assign w_mplier_mag = multiplier_din[N-1]   ? -multiplier_din   : multiplier_din;
    assign w_acc_ext    = 32'(r_acc);
    assign w_product    = r_sign ? -w_acc_ext : w_acc_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_acc            <= '0;
            r_mcand          <= '0;
            r_mplier         <= '0;
            r_cnt            <= '0;
            r_sign           <= 1'b0;
            product_dout     <= '0;
            product_dout_vld <= 1'b0;
            product_end      <= 1'b0;
        end else begin
            product_dout_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (input_vld) begin
                        r_mcand     <= {{N{1'b0}}, w_mcand_mag};
                        r_mplier    <= w_mplier_mag;
                        r_sign      <= multiplicand_din[N-1] ^ multiplier_din[N-1];
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        product_end <= 1'b0;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    product_dout     <= w_product;
                    product_dout_vld <= 1'b1;
                    product_end      <= 1'b1;
                    r_state          <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_mult.sv
// Randomized self-checking bench for q_mult (N=16) against a plain integer-multiply model.
module tb_q_mult;

    localparam int N   = 16;
    localparam int LAT = N + 1;
    localparam int PER = N + 2;

    logic          clk;
    logic          rst_n;
    logic          input_vld;
    logic [N-1:0]  multiplicand_din;
    logic [N-1:0]  multiplier_din;
    logic [31:0]   product_dout;
    logic          product_dout_vld;
    logic          product_end;

    int checks = 0;
    int errors = 0;

    q_mult #(.N(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .input_vld        (input_vld),
        .multiplicand_din (multiplicand_din),
        .multiplier_din   (multiplier_din),
        .product_dout     (product_dout),
        .product_dout_vld (product_dout_vld),
        .product_end      (product_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        return 32'(ia * ib);
    endfunction

    // One operation: pulse input_vld for one cycle, scramble inputs afterwards,
    // then measure latency and check result, pulse width and the end flag.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
        int n;
        logic [31:0] exp;
        exp = model(a, b);
        @(negedge clk);
        input_vld        = 1'b1;
        multiplicand_din = a;
        multiplier_din   = b;
        @(negedge clk);
        input_vld        = 1'b0;
        multiplicand_din = N'($urandom);
        multiplier_din   = N'($urandom);
        n = 0;
        while (!product_dout_vld && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) check({tag, " end_low"}, 32'(product_end), 32'd0);
        end
        check({tag, " latency"}, 32'(n), 32'(LAT));
        check({tag, " product"}, product_dout, exp);
        check({tag, " end_rise"}, 32'(product_end), 32'd1);
        @(negedge clk);
        check({tag, " vld_pulse"}, 32'(product_dout_vld), 32'd0);
        check({tag, " hold"}, product_dout, exp);
        check({tag, " end_hold"}, 32'(product_end), 32'd1);
        $display("op %s: %0d * %0d -> %h (expect %h, latency %0d)",
                 tag, $signed(a), $signed(b), product_dout, exp, n);
    endtask

    logic [N-1:0] a_hist [0:127];
    logic [N-1:0] b_hist [0:127];

    initial begin
        int pulses;
        logic exp_v;
        rst_n            = 1'b0;
        input_vld        = 1'b0;
        multiplicand_din = '0;
        multiplier_din   = '0;
        #12;
        check("reset dout", product_dout, 32'd0);
        check("reset vld", 32'(product_dout_vld), 32'd0);
        check("reset end", 32'(product_end), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases and extremes.
        do_op(16'd3,      16'd5,      "3x5");
        do_op(-16'sd3,    16'd5,      "-3x5");
        do_op(16'd7,      -16'sd1,    "7x-1");
        do_op(-16'sd4,    -16'sd6,    "-4x-6");
        do_op(16'd0,      16'h8000,   "0x-32768");
        do_op(16'h8000,   16'h0000,   "-32768x0");
        do_op(16'h8000,   16'h8000,   "-32768x-32768");
        do_op(16'h7FFF,   16'h8000,   "32767x-32768");
        do_op(16'h7FFF,   16'h7FFF,   "32767x32767");

        for (int i = 0; i < 20; i++) begin
            do_op(N'($urandom), N'($urandom), $sformatf("rand%0d", i));
        end

        // Busy rejection: a second request during BUSY must be dropped.
        @(negedge clk);
        input_vld = 1'b1; multiplicand_din = 16'd2; multiplier_din = 16'd3;
        @(negedge clk);
        input_vld = 1'b0;
        repeat (4) @(negedge clk);
        input_vld = 1'b1; multiplicand_din = 16'd9; multiplier_din = 16'd9;
        @(negedge clk);
        input_vld = 1'b0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (product_dout_vld) begin
                pulses++;
                check("busy product", product_dout, 32'd6);
            end
        end
        check("busy pulses", 32'(pulses), 32'd1);
        $display("op busy-reject: 2*3 with 9*9 during BUSY -> %h, pulses %0d", product_dout, pulses);

        // Back-to-back with input_vld held high and operands changing every cycle.
        @(negedge clk);
        a_hist[0] = N'($urandom); b_hist[0] = N'($urandom);
        input_vld = 1'b1; multiplicand_din = a_hist[0]; multiplier_din = b_hist[0];
        for (int i = 0; i < 5 * PER; i++) begin
            @(negedge clk);
            exp_v = (i >= LAT) && ((i - LAT) % PER == 0);
            check($sformatf("b2b vld@%0d", i), 32'(product_dout_vld), 32'(exp_v));
            if (exp_v) begin
                check($sformatf("b2b product@%0d", i), product_dout,
                      model(a_hist[i-LAT], b_hist[i-LAT]));
                $display("op b2b@%0d: %0d * %0d -> %h", i, $signed(a_hist[i-LAT]),
                         $signed(b_hist[i-LAT]), product_dout);
            end
            a_hist[i+1] = N'($urandom); b_hist[i+1] = N'($urandom);
            multiplicand_din = a_hist[i+1]; multiplier_din = b_hist[i+1];
        end
        input_vld = 1'b0;
        repeat (2 * PER) @(negedge clk);

        // Async reset mid-BUSY, between clock edges.
        do_op(16'd100, 16'd100, "pre-reset");
        @(negedge clk);
        input_vld = 1'b1; multiplicand_din = 16'd11; multiplier_din = 16'd13;
        @(negedge clk);
        input_vld = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async dout", product_dout, 32'd0);
        check("async vld", 32'(product_dout_vld), 32'd0);
        check("async end", 32'(product_end), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (product_dout_vld) pulses++;
        end
        check("async stale pulses", 32'(pulses), 32'd0);
        $display("op async-reset: outputs cleared, stale pulses %0d", pulses);
        do_op(-16'sd7, 16'd9, "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/q_mult.md
Name: q_mult

Overview:
- Sequential signed fixed-point (integer-quantized) multiplier.
- Multiplies two N-bit two's-complement operands and returns a 32-bit signed product.
- Instantiated once per lane inside the parallel convolution units. The downstream adder tree sums the lane products when all lanes assert valid together, so latency must be fixed and data-independent.
- Radix-2 shift-add on operand magnitudes, with a final sign correction.

Parameters:
- N, 16, operand bit width; legal range 2..16, so that 2N <= 32.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- input_vld  input  1  operand valid, active high; sampled on rising edge.
- multiplicand_din  input  N  signed two's-complement multiplicand.
- multiplier_din  input  N  signed two's-complement multiplier.
- product_dout  output  32  signed product, sign-extended to 32 bits; registered.
- product_dout_vld  output  1  one-cycle pulse marking a new product_dout.
- product_end  output  1  level "operation finished / idle-with-result" flag.

Behaviour:
- Reset (async, rst_n=0): state IDLE, product_dout=0, product_dout_vld=0, product_end=0, internal accumulator/counter cleared. Reset asserted mid-operation aborts the operation; no valid pulse follows.
- States: IDLE, BUSY, DONE.
- IDLE: on an edge with input_vld=1:
  - latch |multiplicand_din| and |multiplier_din| as N-bit unsigned magnitudes;
  - latch sign = MSB(multiplicand) XOR MSB(multiplier);
  - clear the 2N-bit accumulator and the counter; drop product_end to 0; go to BUSY.
- BUSY: exactly N cycles, one multiplier bit per cycle, LSB first. If the current bit is 1, add the shifted multiplicand to the accumulator. Increment the counter. After the N-th iteration go to DONE.
- DONE (one cycle):
  - product_dout <= sign ? -(zero-extended accumulator) : accumulator, computed in 32 bits;
  - product_dout_vld <= 1 for exactly this one registered cycle;
  - product_end <= 1; return to IDLE.
- Latency: input_vld sampled at edge k → product_dout/product_dout_vld updated at edge k+N+1 (17 clocks for N=16). Latency is independent of operand values.
- product_dout holds its value until the next completion. product_end stays high until the next operand is accepted.
- input_vld while in BUSY or DONE is ignored; there is no queuing. If input_vld is held high continuously, a new operation starts on the first edge after the block returns to IDLE, giving one result every N+2 clocks.
- The operands are sampled only in the accepting cycle; later changes to the inputs have no effect on the operation in progress.
- Arithmetic:
  - the magnitude of -2^(N-1) is 2^(N-1) and is represented exactly as N-bit unsigned;
  - maximum product (-2^(N-1))^2 = 2^(2N-2) fits positive in 32 bits;
  - a zero operand yields +0, never a negative encoding;
  - no saturation or rounding: the exact integer product.
- All outputs are driven only by registers; no combinational path from inputs to outputs.

Test Plan:
- Reset then 3 × 5 (N=16), input_vld pulsed one cycle → product_dout=0x0000000F with a product_dout_vld pulse exactly 17 clocks later; product_end rises the same edge and stays high.
- -3 × 5 → 0xFFFFFFF1; 7 × -1 → 0xFFFFFFF9; -4 × -6 → 0x00000018; 0 × -32768 → 0x00000000.
- Extremes: -32768 × -32768 → 0x40000000; 32767 × -32768 → 0xC0008000; 32767 × 32767 → 0x3FFF0001.
- Busy rejection: accept 2 × 3, then pulse input_vld with 9 × 9 during BUSY → only 0x00000006 is produced; no second vld pulse.
- Back-to-back: hold input_vld=1 with the operands changing → results appear every 18 clocks, each matching the operands present in its acceptance cycle.
- Async reset asserted mid-BUSY (between clock edges) → all outputs 0 immediately; after release no stale vld pulse; the next operation completes normally.
